// File: rtl/sirv_uarttx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : sirv_uarttx_cfg
// Purpose  : Configurable UART transmitter. A valid/ready byte stream feeds
//            a small TX FIFO. Frames are sent with 5..DATA_W data bits (LSB
//            first), optional even/odd parity and one or two stop bits. The
//            frame start is gated by enable and active-low CTS.
// Ports    : clock, reset         - clock, asynchronous active-high reset
//            io_en                - enable for FIFO push and frame start
//            io_in_valid/ready/bits - push handshake and data word
//            io_div               - bit period minus one, in clocks
//            io_nbits             - data bits per frame (illegal -> DATA_W)
//            io_parity            - 00/11 none, 01 even, 10 odd
//            io_nstop             - 0 one stop bit, 1 two stop bits
//            io_cts_n             - active-low clear-to-send
//            io_out               - serial TX line (idles high)
//            io_busy              - frame in progress
//            io_count             - FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module sirv_uarttx_cfg #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_en,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [DATA_W-1:0] io_in_bits,
    input  logic [DIV_W-1:0]  io_div,
    input  logic [3:0]        io_nbits,
    input  logic [1:0]        io_parity,
    input  logic              io_nstop,
    input  logic              io_cts_n,
    output logic              io_out,
    output logic              io_busy,
    output logic [CNT_W-1:0]  io_count
);

    localparam int AW   = $clog2(DEPTH);
    // data bits + parity + two stop bits
    localparam int SH_W = DATA_W + 3;
    localparam int BC_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DIV_W-1:0]  presc;
    logic [DIV_W-1:0]  div_q;
    logic [BC_W-1:0]   bitcnt;
    logic [SH_W-1:0]   shifter;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              start_cond;
    logic              frame_done;
    logic [DATA_W-1:0] head;
    logic [3:0]        eff_nbits;
    logic [DATA_W-1:0] masked;
    logic              par_en;
    logic              par_bit;
    logic [SH_W-1:0]   sh_load;
    logic [BC_W-1:0]   cnt_load;

    // ------------------------------------------------------------------
    // FIFO flags and handshake
    // ------------------------------------------------------------------
    assign full        = (io_count == CNT_W'(DEPTH));
    assign empty       = (io_count == '0);
    assign io_in_ready = io_en & ~full;
    assign push        = io_in_valid & io_in_ready;
    assign head        = mem[rd_ptr];

    assign start_cond  = io_en & ~io_cts_n & ~empty;
    assign frame_done  = (state == SEND) && (presc == '0) && (bitcnt == '0);
    // A word leaves the FIFO only when a frame starts, either from IDLE or
    // directly on the last edge of the previous frame (no idle gap).
    assign pop         = start_cond & ((state == IDLE) | frame_done);

    // ------------------------------------------------------------------
    // Frame image built from the FIFO head and the live configuration.
    // Everything the frame needs except the bit period is folded into the
    // shifter and bit counter here, so later config changes cannot reach
    // the frame in flight.
    // ------------------------------------------------------------------
    always_comb begin
        if ((io_nbits < 4'd5) || (io_nbits > 4'(DATA_W))) begin
            eff_nbits = 4'(DATA_W);
        end else begin
            eff_nbits = io_nbits;
        end

        masked = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(eff_nbits)) begin
                masked[i] = head[i];
            end
        end

        par_en  = (io_parity == 2'b01) || (io_parity == 2'b10);
        par_bit = (^masked) ^ (io_parity == 2'b10);

        // Unused upper positions stay 1, which doubles as the stop bits.
        sh_load = '1;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(eff_nbits)) begin
                sh_load[i] = head[i];
            end
        end
        for (int i = 0; i < SH_W; i++) begin
            if (par_en && (i == int'(eff_nbits))) begin
                sh_load[i] = par_bit;
            end
        end

        cnt_load = eff_nbits + {3'b000, par_en} + (io_nstop ? 4'd2 : 4'd1);
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed on the data array)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= io_in_bits;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            io_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                io_count <= io_count + CNT_W'(1);
            end else if (pop && !push) begin
                io_count <= io_count - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit state machine with registered line and busy outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            io_out  <= 1'b1;
            io_busy <= 1'b0;
            presc   <= '0;
            div_q   <= '0;
            bitcnt  <= '0;
            shifter <= '1;
        end else if (pop) begin
            // Start bit goes out on this edge.
            state   <= SEND;
            io_busy <= 1'b1;
            io_out  <= 1'b0;
            shifter <= sh_load;
            bitcnt  <= cnt_load;
            presc   <= io_div;
            div_q   <= io_div;
        end else begin
            case (state)
                IDLE: begin
                    io_out  <= 1'b1;
                    io_busy <= 1'b0;
                end
                SEND: begin
                    if (presc != '0) begin
                        presc <= presc - DIV_W'(1);
                    end else if (bitcnt != '0) begin
                        io_out  <= shifter[0];
                        shifter <= {1'b1, shifter[SH_W-1:1]};
                        bitcnt  <= bitcnt - BC_W'(1);
                        presc   <= div_q;
                    end else begin
                        state   <= IDLE;
                        io_busy <= 1'b0;
                        io_out  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
